// File: rtl/sched_pkg.sv
// Shared types and field helpers for the dual-issue scheduler.
// Instruction format: [15:12] op (0 = NOP), [11] imm, [10:8] rd, [7:5] rs1, [4:2] rs2.
package sched_pkg;

    localparam int IW      = 16;
    localparam int RW      = 3;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int IMM_BIT = 11;
    localparam int RD_HI   = 10;
    localparam int RD_LO   = 8;
    localparam int RS1_HI  = 7;
    localparam int RS1_LO  = 5;
    localparam int RS2_HI  = 4;
    localparam int RS2_LO  = 2;

    typedef logic [IW-1:0] instr_t;
    typedef logic [RW-1:0] reg_t;

    localparam instr_t NOP = '0;

    typedef struct packed {
        logic valid;
        reg_t rd;
    } sb_ent_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic is_op(input instr_t i);
        return i[OP_HI:OP_LO] != '0;
    endfunction

    // rs2 is only a source when the imm bit is clear
    function automatic logic reads_reg(input instr_t i, input reg_t r);
        return is_op(i) &&
               ((i[RS1_HI:RS1_LO] == r) ||
                (!i[IMM_BIT] && (i[RS2_HI:RS2_LO] == r)));
    endfunction

    function automatic sb_ent_t writes_reg(input instr_t i);
        sb_ent_t e;
        e.valid = is_op(i);
        e.rd    = i[RD_HI:RD_LO];
        return e;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: DEPTH stages x 2 slots of {valid, rd}.
// Ports: clk, rst_n (sync, active low), hold (freeze), wr0/wr1 (issued rds),
//        rd_instr0/1 (instrs to test), raw_hit0/1 (instr reads an in-flight rd).
module hazard_scoreboard
    import sched_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    hold,
    input  sb_ent_t wr0,
    input  sb_ent_t wr1,
    input  instr_t  rd_instr0,
    input  instr_t  rd_instr1,
    output logic    raw_hit0,
    output logic    raw_hit1
);

    sb_ent_t stage [DEPTH][2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k][0] <= '0;
                stage[k][1] <= '0;
            end
        end else if (!hold) begin
            stage[0][0] <= wr0;
            stage[0][1] <= wr1;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k][0] <= stage[k-1][0];
                stage[k][1] <= stage[k-1][1];
            end
        end
    end

    always_comb begin
        raw_hit0 = 1'b0;
        raw_hit1 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int s = 0; s < 2; s++) begin
                if (stage[k][s].valid) begin
                    if (reads_reg(rd_instr0, stage[k][s].rd))
                        raw_hit0 = 1'b1;
                    if (reads_reg(rd_instr1, stage[k][s].rd))
                        raw_hit1 = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: fetch pair queue, hazard checks, issue regs.
// Ports: clk, rst_n (sync, active low); fetch_valid/instr1/instr2/ready;
//        exec_hold, flush; issue_instr1/2, issue_valid1/2; stall, stall_cnt.
module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int IW     = 16,
    parameter int QDEPTH = 4,
    parameter int DEPTH  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_valid,
    input  logic [IW-1:0] fetch_instr1,
    input  logic [IW-1:0] fetch_instr2,
    output logic          fetch_ready,
    input  logic          exec_hold,
    input  logic          flush,
    output logic [IW-1:0] issue_instr1,
    output logic [IW-1:0] issue_instr2,
    output logic          issue_valid1,
    output logic          issue_valid2,
    output logic          stall,
    output logic [15:0]   stall_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    instr_t  q [QDEPTH];
    ptr_t    rd_ptr, wr_ptr;
    cnt_t    count;
    state_t  state, next_state;
    logic    do_issue, do_hold, do_flush;
    instr_t  h0, h1;
    logic    h0_ok, h1_ok, hit0, hit1;
    logic    iss0, iss1, pair_ok;
    logic    keep1, keep2, accept, stall_next;
    logic [1:0] push_n, pop_n;
    sb_ent_t w0, w1, sb_w0, sb_w1;

    assign h0          = q[rd_ptr];
    assign h1          = q[rd_ptr + ptr_t'(1)];
    assign h0_ok       = count != '0;
    assign h1_ok       = count >= cnt_t'(2);
    assign fetch_ready = count <= cnt_t'(QDEPTH - 2);

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= next_state;
    end

    // ---- FSM: next state (flush beats hold) ----
    always_comb begin
        next_state = ST_RUN;
        if (flush)          next_state = ST_FLUSH;
        else if (exec_hold) next_state = ST_HOLD;
    end

    // ---- FSM: controls for the coming edge ----
    // In the FLUSH cycle the queue has just been emptied, so nothing issues.
    always_comb begin
        do_flush = 1'b0;
        do_hold  = 1'b0;
        do_issue = 1'b0;
        unique case (next_state)
            ST_FLUSH: do_flush = 1'b1;
            ST_HOLD:  do_hold  = 1'b1;
            default:  do_issue = (state != ST_FLUSH);
        endcase
    end

    // ---- pair check ----
    always_comb begin
        w0      = writes_reg(h0);
        w1      = writes_reg(h1);
        pair_ok = !reads_reg(h1, w0.rd) &&
                  (w1.rd != w0.rd) &&
                  !reads_reg(h0, w1.rd);
        iss0    = do_issue && h0_ok && !hit0;
        iss1    = iss0 && h1_ok && !hit1 && pair_ok;
        pop_n   = {1'b0, iss0} + {1'b0, iss1};
        keep1   = is_op(fetch_instr1);
        keep2   = is_op(fetch_instr2);
        accept  = fetch_valid && fetch_ready && !do_flush;
        push_n  = accept ? ({1'b0, keep1} + {1'b0, keep2}) : 2'd0;
        // flushed contents are not counted as a stall
        stall_next = h0_ok && !iss0 && !do_flush;
        sb_w0   = iss0 ? w0 : '0;
        sb_w1   = iss1 ? w1 : '0;
    end

    hazard_scoreboard #(
        .DEPTH(DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (do_hold),
        .wr0      (sb_w0),
        .wr1      (sb_w1),
        .rd_instr0(h0),
        .rd_instr1(h1),
        .raw_hit0 (hit0),
        .raw_hit1 (hit1)
    );

    // ---- queue storage ----
    always_ff @(posedge clk) begin
        if (accept && keep1)
            q[wr_ptr] <= fetch_instr1;
        if (accept && keep2)
            q[keep1 ? wr_ptr + ptr_t'(1) : wr_ptr] <= fetch_instr2;
    end

    // ---- queue pointers ----
    always_ff @(posedge clk) begin
        if (!rst_n || do_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ptr_t'(push_n);
            rd_ptr <= rd_ptr + ptr_t'(pop_n);
            count  <= count + cnt_t'(push_n) - cnt_t'(pop_n);
        end
    end

    // ---- issue outputs and stall counter ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_instr1 <= NOP;
            issue_instr2 <= NOP;
            issue_valid1 <= 1'b0;
            issue_valid2 <= 1'b0;
            stall        <= 1'b0;
            stall_cnt    <= '0;
        end else if (!do_hold) begin
            issue_instr1 <= iss0 ? h0 : NOP;
            issue_instr2 <= iss1 ? h1 : NOP;
            issue_valid1 <= iss0;
            issue_valid2 <= iss1;
            stall        <= stall_next;
            if (stall_next && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: order scoreboard plus directed timing checks.
// Expected issue order is queued as fetch pairs are accepted.
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [15:0] fetch_instr1, fetch_instr2;
    logic        fetch_ready;
    logic        exec_hold, flush;
    logic [15:0] issue_instr1, issue_instr2;
    logic        issue_valid1, issue_valid2;
    logic        stall;
    logic [15:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    dual_issue_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_instr1(fetch_instr1),
        .fetch_instr2(fetch_instr2),
        .fetch_ready (fetch_ready),
        .exec_hold   (exec_hold),
        .flush       (flush),
        .issue_instr1(issue_instr1),
        .issue_instr2(issue_instr2),
        .issue_valid1(issue_valid1),
        .issue_valid2(issue_valid2),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a,
                         input logic [15:0] b);
        fetch_valid  = v;
        fetch_instr1 = a;
        fetch_instr2 = b;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] got);
        if (exp_q.size() == 0) chk({tag, "_unexpected"}, got, 32'h0);
        else                   chk(tag, got, exp_q.pop_front());
    endtask

    // one clock: queue accepted instrs, then compare fresh issues
    task automatic tick();
        bit acc, clr, run;
        logic [15:0] a, b;
        a   = fetch_instr1;
        b   = fetch_instr2;
        acc = rst_n && !flush && fetch_valid && fetch_ready;
        clr = !rst_n || flush;
        run = rst_n && !flush && !exec_hold;
        if (acc) begin
            if (a[15:12] != 4'd0) exp_q.push_back(a);
            if (b[15:12] != 4'd0) exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        if (clr) begin
            exp_q.delete();
        end else if (run) begin
            if (issue_valid1) pop_chk("order_slot1", issue_instr1);
            if (issue_valid2) pop_chk("order_slot2", issue_instr2);
        end
        chk("v2_without_v1", {31'd0, issue_valid2 && !issue_valid1}, 32'd0);
    endtask

    task automatic expect_issue(input string tag, input logic [1:0] v,
                                input logic [15:0] i1, input logic [15:0] i2);
        chk({tag, "_valid"}, {30'd0, issue_valid1, issue_valid2}, {30'd0, v});
        chk({tag, "_instr1"}, {16'd0, issue_instr1}, {16'd0, i1});
        chk({tag, "_instr2"}, {16'd0, issue_instr2}, {16'd0, i2});
    endtask

    task automatic expect_reset(input string tag);
        expect_issue(tag, 2'b00, 16'h0, 16'h0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
        chk({tag, "_ready"}, {31'd0, fetch_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit took;
        rst_n = 1'b0;
        flush = 1'b0;
        exec_hold = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        tick();
        tick();
        rst_n = 1'b1;
        expect_reset("reset");

        // independent pair dual-issues one cycle after enqueue
        drive(1'b1, 16'h114C, 16'h1EE0);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        expect_issue("t1_latency", 2'b00, 16'h0, 16'h0);
        tick();
        expect_issue("t1_pair", 2'b11, 16'h114C, 16'h1EE0);
        repeat (4) tick();

        // RAW pair: consumer issues 4 cycles after producer
        drive(1'b1, 16'h114C, 16'h1434);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        tick();
        expect_issue("t2_first", 2'b10, 16'h114C, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_stall", {31'd0, stall}, 32'd1);
            chk("t2_wait_valid", {30'd0, issue_valid1, issue_valid2}, 32'd0);
        end
        tick();
        expect_issue("t2_second", 2'b10, 16'h1434, 16'h0);
        chk("t2_stall_clear", {31'd0, stall}, 32'd0);
        chk("t2_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        repeat (4) tick();

        // hold freezes outputs and scoreboard, enqueue continues
        drive(1'b1, 16'h1EE0, 16'h0000);
        tick();
        drive(1'b1, 16'h12C0, 16'h0000);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        expect_issue("h_issue", 2'b10, 16'h1EE0, 16'h0);
        exec_hold = 1'b1;
        drive(1'b1, 16'h1EE0, 16'h0000);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        expect_issue("h_frozen1", 2'b10, 16'h1EE0, 16'h0);
        tick();
        expect_issue("h_frozen2", 2'b10, 16'h1EE0, 16'h0);
        chk("h_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        exec_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("h_sb_frozen_stall", {31'd0, stall}, 32'd1);
            chk("h_sb_frozen_valid", {30'd0, issue_valid1, issue_valid2}, 32'd0);
        end
        tick();
        expect_issue("h_consumer", 2'b10, 16'h12C0, 16'h0);
        chk("h_stall_cnt_after", {16'd0, stall_cnt}, 32'd6);
        tick();
        expect_issue("h_war_split", 2'b10, 16'h1EE0, 16'h0);
        repeat (4) tick();

        // flush during stall: queue emptied, r1 still in flight
        drive(1'b1, 16'h114C, 16'h1434);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        tick();
        expect_issue("f_producer", 2'b10, 16'h114C, 16'h0);
        flush = 1'b1;
        exec_hold = 1'b1;
        drive(1'b1, 16'h1EE0, 16'h0000);
        tick();
        flush = 1'b0;
        exec_hold = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        expect_issue("f_flushed", 2'b00, 16'h0, 16'h0);
        chk("f_stall", {31'd0, stall}, 32'd0);
        chk("f_ready", {31'd0, fetch_ready}, 32'd1);
        drive(1'b1, 16'h1434, 16'h0000);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        chk("f_enq_valid", {30'd0, issue_valid1, issue_valid2}, 32'd0);
        tick();
        chk("f_r1_blocks_valid", {30'd0, issue_valid1, issue_valid2}, 32'd0);
        chk("f_r1_blocks_stall", {31'd0, stall}, 32'd1);
        tick();
        expect_issue("f_after", 2'b10, 16'h1434, 16'h0);
        chk("f_stall_cnt", {16'd0, stall_cnt}, 32'd7);
        repeat (4) tick();

        // back-to-back dependent pairs: back-pressure, no loss
        drive(1'b1, 16'h114C, 16'h1434);
        tick();
        drive(1'b1, 16'h1280, 16'h1EE0);
        chk("b_ready_cnt2", {31'd0, fetch_ready}, 32'd1);
        tick();
        drive(1'b1, 16'h1434, 16'h12C0);
        chk("b_ready_cnt3", {31'd0, fetch_ready}, 32'd0);
        took = 1'b0;
        for (int k = 0; k < 40; k++) begin
            took = fetch_ready;
            tick();
            if (took) break;
        end
        drive(1'b0, 16'h0, 16'h0);
        chk("b_accept", {31'd0, took}, 32'd1);
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("b_drained", exp_q.size(), 32'd0);
        repeat (4) tick();
        chk("b_ready_end", {31'd0, fetch_ready}, 32'd1);

        // reset with a full queue
        exec_hold = 1'b1;
        drive(1'b1, 16'h114C, 16'h1434);
        tick();
        drive(1'b1, 16'h1EE0, 16'h1280);
        tick();
        drive(1'b0, 16'h0, 16'h0);
        chk("r_full", {31'd0, fetch_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exec_hold = 1'b0;
        expect_reset("r_mid");
        tick();
        tick();
        expect_issue("r_empty", 2'b00, 16'h0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
